// File: rtl/capture_bram_pkg.sv
// capture_bram_pkg: state encoding and trigger-mode constants shared by the capture block
package capture_bram_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;
  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_SW   = 2'd1;
  localparam logic [1:0] TRIG_RISE = 2'd2;
  localparam logic [1:0] TRIG_FALL = 2'd3;
endpackage

// File: rtl/capture_bram_trigger.sv
// capture_trigger: combinational trigger pulse from immediate, software or threshold-crossing conditions
module capture_trigger
  import capture_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  armed,
  input  logic                  din_valid,
  input  logic                  sw_trig,
  input  logic [1:0]            trig_mode,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  trig
);
  logic signed [DATA_WIDTH-1:0] prev_q, prev_d, din_s, thr_s;
  logic seen_q, seen_d, sw_q, sw_d, rise, fall, hit;
  always_comb begin
    din_s  = $signed(din);
    thr_s  = $signed(threshold);
    prev_d = din_valid ? din_s : prev_q;
    seen_d = seen_q | din_valid;
    sw_d   = clr ? 1'b0 : sw_q | (armed & sw_trig);
    rise   = seen_q && prev_q < thr_s && din_s >= thr_s;
    fall   = seen_q && prev_q > thr_s && din_s <= thr_s;
    hit    = trig_mode == TRIG_IMM  ? 1'b1 :
             trig_mode == TRIG_SW   ? sw_trig | sw_q :
             trig_mode == TRIG_RISE ? rise : fall;
    trig   = armed & din_valid & hit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      seen_q <= 1'b0;
      sw_q   <= 1'b0;
    end else begin
      prev_q <= prev_d;
      seen_q <= seen_d;
      sw_q   <= sw_d;
    end
  end
endmodule

// File: rtl/capture_bram.sv
// capture_bram: triggered, decimating sample capture into a BRAM write port with one-shot or ring mode
module capture_bram
  import capture_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dec_rate,
  input  logic                  arm,
  input  logic [1:0]            trig_mode,
  input  logic                  sw_trig,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  continous,
  output logic                  busy,
  output logic                  triggered,
  output logic                  finish,
  output logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_data_o
);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, last_addr_q, last_addr_d, bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_data_q, bram_data_d;
  logic [31:0] dec_count_q, dec_count_d;
  logic arm_q, bram_we_q, bram_we_d, arm_rise, trig, wr;
  capture_trigger #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
    .clk       (clk),
    .rst       (rst),
    .clr       (arm_rise),
    .armed     (state_q == ARMED),
    .din_valid (din_valid),
    .sw_trig   (sw_trig),
    .trig_mode (trig_mode),
    .din       (din),
    .threshold (threshold),
    .trig      (trig)
  );
  always_comb begin
    arm_rise    = arm & ~arm_q;
    wr          = !arm_rise && (trig || (state_q == CAPTURE && din_valid && dec_count_q == dec_rate));
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    dec_count_d = dec_count_q;
    bram_we_d   = wr;
    bram_addr_d = wr ? wr_ptr_q : bram_addr_q;
    bram_data_d = wr ? din : bram_data_q;
    last_addr_d = wr ? wr_ptr_q : last_addr_q;
    if (arm_rise) begin
      state_d     = ARMED;
      wr_ptr_d    = '0;
      dec_count_d = '0;
    end else if (wr) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      dec_count_d = '0;
      state_d     = (&wr_ptr_q && !continous) ? DONE : CAPTURE;
    end else if (state_q == CAPTURE && din_valid) begin
      dec_count_d = dec_count_q + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      dec_count_q <= '0;
      last_addr_q <= '0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_we_q   <= 1'b0;
      arm_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      dec_count_q <= dec_count_d;
      last_addr_q <= last_addr_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      bram_we_q   <= bram_we_d;
      arm_q       <= arm;
    end
  end
  assign busy        = state_q == ARMED || state_q == CAPTURE;
  assign triggered   = state_q == CAPTURE;
  assign finish      = state_q == DONE;
  assign last_addr   = last_addr_q;
  assign bram_addr   = bram_addr_q;
  assign bram_we     = bram_we_q;
  assign bram_data_o = bram_data_q;
endmodule

// File: tb/tb_capture_bram.sv
// tb_capture_bram: directed and randomized checks of capture_bram against a sample-counting reference model
module tb_capture_bram;
  localparam int AW = 4;
  localparam int DW = 16;
  logic clk = 0, rst = 1, arm = 0, sw_trig = 0, din_valid = 0, continous = 0;
  logic [31:0] dec_rate = 0;
  logic [1:0] trig_mode = 0;
  logic [DW-1:0] threshold = 0, din = 0;
  logic busy, triggered, finish, bram_we;
  logic [AW-1:0] last_addr, bram_addr;
  logic [DW-1:0] bram_data_o;
  capture_bram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .dec_rate(dec_rate), .arm(arm), .trig_mode(trig_mode),
    .sw_trig(sw_trig), .threshold(threshold), .din(din), .din_valid(din_valid),
    .continous(continous), .busy(busy), .triggered(triggered), .finish(finish),
    .last_addr(last_addr), .bram_addr(bram_addr), .bram_we(bram_we), .bram_data_o(bram_data_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t wlog[$];
  int m_mode = 0, m_k = 0, m_nw = 0;
  bit m_arm_prev = 1, m_seen = 0, m_sw = 0, arm_rise, fire, w;
  logic signed [DW-1:0] m_prev = 0, xs, ts;
  logic e_we = 0;
  logic [AW-1:0] e_addr = 0, e_last = 0;
  logic [DW-1:0] e_data = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_arm_prev = 1; m_prev = 0; m_seen = 0; m_sw = 0; m_k = 0; m_nw = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_last = 0;
    end else begin
      arm_rise = arm && !m_arm_prev;
      xs = din;
      ts = threshold;
      fire = din_valid && (trig_mode == 0 || (trig_mode == 1 && (sw_trig || m_sw)) ||
             (trig_mode == 2 && m_seen && m_prev < ts && xs >= ts) ||
             (trig_mode == 3 && m_seen && m_prev > ts && xs <= ts));
      if (arm_rise) m_sw = 0;
      else if (m_mode == 1 && sw_trig) m_sw = 1;
      e_we = 0;
      w = 0;
      if (arm_rise) begin
        m_mode = 1; m_k = 0; m_nw = 0;
      end else if (m_mode == 1 && fire) begin
        w = 1; m_mode = 2; m_k = 1;
      end else if (m_mode == 2 && din_valid) begin
        w = (m_k % (int'(dec_rate) + 1)) == 0;
        m_k++;
      end
      if (w) begin
        e_we = 1;
        e_addr = AW'(m_nw);
        e_data = din;
        e_last = e_addr;
        m_nw++;
        if (e_addr == '1 && !continous) m_mode = 3;
      end
      if (din_valid) begin
        m_prev = din;
        m_seen = 1;
      end
      m_arm_prev = arm;
    end
  end
  always @(negedge clk) begin
    chk("we", bram_we, e_we);
    chk("addr", bram_addr, e_addr);
    chk("data", bram_data_o, e_data);
    chk("last", last_addr, e_last);
    chk("busy", busy, m_mode == 1 || m_mode == 2);
    chk("triggered", triggered, m_mode == 2);
    chk("finish", finish, m_mode == 3);
    if (bram_we) wlog.push_back('{bram_addr, bram_data_o});
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic arm_pulse();
    din_valid = 0; arm = 0; tick();
    arm = 1; tick();
    arm = 0;
    wlog.delete();
  endtask
  task automatic ramp(int n, int start);
    for (int i = 0; i < n; i++) begin
      din = DW'(start + i); din_valid = 1; tick();
    end
    din_valid = 0;
  endtask
  task automatic feed(int v);
    din = DW'(v); din_valid = 1; tick();
    din_valid = 0;
  endtask
  initial begin
    tick(2);
    rst = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    arm_pulse();
    ramp(20, 0);
    tick(2);
    chk("t1_count", wlog.size(), 16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      chk("t1_addr", wlog[i].a, i);
      chk("t1_data", wlog[i].d, i);
    end
    chk("t1_finish", finish, 1);
    chk("t1_last", last_addr, 15);
    dec_rate = 2;
    arm_pulse();
    ramp(12, 0);
    tick(2);
    chk("t2_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t2_addr", wlog[i].a, i);
      chk("t2_data", wlog[i].d, 3 * i);
    end
    dec_rate = 0; trig_mode = 2; threshold = 16'd100;
    arm_pulse();
    feed(90); feed(95); feed(99);
    chk("t3_nowrite", wlog.size(), 0);
    feed(100); feed(120);
    tick(2);
    chk("t3_count", wlog.size(), 2);
    if (wlog.size() > 0) begin
      chk("t3_addr0", wlog[0].a, 0);
      chk("t3_data0", wlog[0].d, 100);
    end
    trig_mode = 3; threshold = DW'(-50);
    arm_pulse();
    feed(-40);
    chk("t4_nowrite", wlog.size(), 0);
    feed(-50);
    for (int i = 0; i < 6; i++) begin
      din = DW'(i); din_valid = (i % 2) == 0; tick();
    end
    din_valid = 0;
    tick(2);
    chk("t4_count", wlog.size(), 4);
    if (wlog.size() > 1) begin
      chk("t4_data0", wlog[0].d, 16'hFFCE);
      chk("t4_data1", wlog[1].d, 0);
    end
    trig_mode = 0; continous = 1;
    arm_pulse();
    ramp(20, 0);
    tick(2);
    chk("t5_finish_ring", finish, 0);
    if (wlog.size() > 16) begin
      chk("t5_wrap_addr", wlog[16].a, 0);
      chk("t5_wrap_data", wlog[16].d, 16);
    end
    continous = 0;
    ramp(16, 20);
    tick(2);
    chk("t5_count", wlog.size(), 32);
    chk("t5_finish", finish, 1);
    chk("t5_last", last_addr, 15);
    arm = 0; tick();
    arm = 1; tick();
    wlog.delete();
    ramp(4, 0);
    din = 4; din_valid = 1; rst = 1;
    tick(2);
    rst = 0;
    ramp(5, 5);
    tick(2);
    chk("t6_count", wlog.size(), 4);
    chk("t6_busy", busy, 0);
    chk("t6_addr", bram_addr, 0);
    chk("t6_last", last_addr, 0);
    arm = 0; tick();
    arm = 1; tick();
    chk("t6_rearm", busy, 1);
    for (int c = 0; c < 5000; c++) begin
      rst = $urandom_range(999) < 3;
      if ($urandom_range(99) < 3) arm = ~arm;
      if (m_mode != 2 && $urandom_range(99) < 5) dec_rate = $urandom_range(3);
      if ($urandom_range(99) < 2) trig_mode = 2'($urandom_range(3));
      if ($urandom_range(99) < 2) threshold = DW'(int'($urandom_range(200)) - 100);
      if ($urandom_range(99) < 1) continous = ~continous;
      sw_trig = $urandom_range(99) < 3;
      din_valid = $urandom_range(99) < 70;
      din = DW'(int'($urandom_range(300)) - 150);
      tick();
    end
    rst = 0; din_valid = 0; sw_trig = 0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
